ising_field_accum: RTL

Sequential, parametrised successor to the combinational J·σ matrix-vector multiplier in the Ising-solver datapath. It computes the local-field vector h_i = Σ_j J[i][j]·s_j for a VECTOR_WIDTH-spin system, where s_j = +1 when sigma bit j is 1 and −1 when it is 0. The coupling matrix is streamed in one column per cycle over a valid/ready handshake, and the signed field vector is returned over a second valid/ready handshake. It sits between the J-matrix memory reader and the spin-update logic.

---
 rtl/ising_field_accum.sv | 103 ++++++++++
 1 files changed

// File: rtl/ising_field_accum.sv
// ising_field_accum: sequential J*sigma local-field accumulator.
// Streams one column of J per cycle and accumulates h_i = sum_j J[i][j]*s_j,
// where s_j = +1 for sigma bit 1 and -1 for sigma bit 0.
module ising_field_accum #(
  parameter  int unsigned VECTOR_WIDTH = 8,
  parameter  int unsigned N            = 4,
  localparam int unsigned ACC_WIDTH    = N + $clog2(VECTOR_WIDTH) + 1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic [VECTOR_WIDTH-1:0]           sigma_vector,
  input  logic                              col_valid,
  output logic                              col_ready,
  input  logic [VECTOR_WIDTH*N-1:0]         J_Column,
  output logic [VECTOR_WIDTH*ACC_WIDTH-1:0] field_out,
  output logic                              field_valid,
  input  logic                              field_ready,
  output logic                              busy
);

  localparam int unsigned CNT_W = (VECTOR_WIDTH > 1) ? $clog2(VECTOR_WIDTH) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ACCUM = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]                  state;
  logic [1:0]                  state_nxt;
  logic [CNT_W-1:0]            col_cnt;
  logic [VECTOR_WIDTH-1:0]     sigma_q;
  logic signed [ACC_WIDTH-1:0] acc     [VECTOR_WIDTH];
  logic signed [ACC_WIDTH-1:0] acc_nxt [VECTOR_WIDTH];
  logic                        start_go;
  logic                        col_fire;
  logic                        last_col;

  assign start_go = (state == S_IDLE) && start;
  assign col_fire = (state == S_ACCUM) && col_valid;
  assign last_col = (col_cnt == CNT_W'(VECTOR_WIDTH - 1));

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_ACCUM;
      S_ACCUM: if (col_fire && last_col) state_nxt = S_DONE;
      S_DONE:  if (field_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // State register and registered control decodes
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      col_ready   <= 1'b0;
      field_valid <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_nxt;
      col_ready   <= (state_nxt == S_ACCUM);
      field_valid <= (state_nxt == S_DONE);
      busy        <= (state_nxt == S_ACCUM) || (state_nxt == S_DONE);
    end
  end

  // Per-row add or subtract of the sign-extended column element
  always_comb begin
    for (int unsigned i = 0; i < VECTOR_WIDTH; i++) begin
      if (sigma_q[col_cnt]) begin
        acc_nxt[i] = acc[i] + ACC_WIDTH'($signed(J_Column[i*N +: N]));
      end else begin
        acc_nxt[i] = acc[i] - ACC_WIDTH'($signed(J_Column[i*N +: N]));
      end
    end
  end

  // Accumulators, column counter and latched spin vector
  always_ff @(posedge clk) begin
    if (rst) begin
      col_cnt <= '0;
      sigma_q <= '0;
      for (int unsigned i = 0; i < VECTOR_WIDTH; i++) acc[i] <= '0;
    end else if (start_go) begin
      col_cnt <= '0;
      sigma_q <= sigma_vector;
      for (int unsigned i = 0; i < VECTOR_WIDTH; i++) acc[i] <= '0;
    end else if (col_fire) begin
      col_cnt <= last_col ? '0 : col_cnt + CNT_W'(1);
      for (int unsigned i = 0; i < VECTOR_WIDTH; i++) acc[i] <= acc_nxt[i];
    end
  end

  // Flatten accumulators onto the result bus
  always_comb begin
    field_out = '0;
    for (int unsigned i = 0; i < VECTOR_WIDTH; i++) begin
      field_out[i*ACC_WIDTH +: ACC_WIDTH] = acc[i];
    end
  end

endmodule
